// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read streamer.
// Imported by the streamer top, its buffer and its property checker.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } stream_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int BEAT_W    = 8;

endpackage

// File: rtl/fifo_rd_streamer_props.sv
// Read-safety and stream-stability properties for fifo_rd_streamer.
// Instantiated alongside the streamer; holds no state of its own.
module fifo_rd_streamer_props
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic             clk,
    input logic             rst_,
    input logic             fifo_empty,
    input logic             fifo_read,
    input logic [WIDTH-1:0] out_data,
    input logic             out_valid,
    input logic             out_ready,
    input logic             out_last
);

    a_no_read_empty: assert property (
        @(posedge clk) disable iff (!rst_)
        fifo_read |-> !fifo_empty
    );

    a_stream_hold: assert property (
        @(posedge clk) disable iff (!rst_)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_last))
    );

endmodule

// File: rtl/skid_buf2.sv
// Two-entry register buffer: head is presented, tail absorbs one extra word.
// Push and pop in the same cycle leave the count unchanged.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= push_data;
                    else               r_tail <= push_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // a full buffer shifts; a single entry is simply replaced
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end else begin
                        r_head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = r_head;
    assign cnt       = r_cnt;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains sync_fifo into a valid/ready stream with a per-burst last marker.
// A 2-entry buffer covers the one-cycle FIFO read latency at full rate.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      words_sent,
    output logic             busy
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    stream_state_e     r_state;
    logic              r_inflight;
    logic [BEAT_W-1:0] r_beat;
    logic [15:0]       r_words;

    logic [1:0] w_cnt;
    logic [1:0] w_occ;
    logic [1:0] w_occ_net;
    logic       w_pop;

    skid_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst_      (rst_),
        .push      (r_inflight),
        .push_data (fifo_data_out),
        .pop       (w_pop),
        .head_data (out_data),
        .cnt       (w_cnt)
    );

    assign out_valid = (w_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_occ     = w_cnt + {1'b0, r_inflight};
    // a pop frees a slot this cycle, so occupancy net of it decides the read
    assign w_occ_net = w_occ - {1'b0, w_pop};
    assign fifo_read = rst_ && en && !fifo_empty && (w_occ_net < 2'd2);

    assign out_last   = out_valid && (r_beat == LAST_BEAT);
    assign words_sent = r_words;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_words    <= '0;
        end else begin
            r_inflight <= fifo_read;
            if (w_pop) begin
                r_words <= r_words + 16'd1;
                if (r_beat == LAST_BEAT) r_beat <= '0;
                else                     r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (en) r_state <= RUN;
                end
                RUN: begin
                    if (!en) r_state <= (w_occ != 2'd0) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (en)                   r_state <= RUN;
                    else if (w_occ == 2'd0)   r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer against a behavioural sync_fifo.
// A second instance with BURST_LEN=1 shares the FIFO inputs.
module tb_fifo_rd_streamer;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data_out = '0;

    logic        fifo_read, out_valid, out_last, busy;
    logic [15:0] out_data, words_sent;
    logic        fifo_read_1, out_valid_1, out_last_1, busy_1;
    logic [15:0] out_data_1, words_sent_1;

    logic [15:0] q[$];
    logic [15:0] got_d[$];
    logic        got_l[$];
    logic [15:0] pop_w;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int rd_viol = 0;
    int last1_viol = 0;
    int dut1_mis = 0;
    int b;
    int n;

    fifo_rd_streamer #(.WIDTH(16), .BURST_LEN(4)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .words_sent    (words_sent),
        .busy          (busy)
    );

    fifo_rd_streamer #(.WIDTH(16), .BURST_LEN(1)) dut1 (
        .clk           (clk),
        .rst_          (rst_),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read_1),
        .out_data      (out_data_1),
        .out_valid     (out_valid_1),
        .out_ready     (out_ready),
        .out_last      (out_last_1),
        .words_sent    (words_sent_1),
        .busy          (busy_1)
    );

    fifo_rd_streamer_props #(.WIDTH(16)) u_props (
        .clk        (clk),
        .rst_       (rst_),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // sync_fifo model: data one cycle after the read strobe
    always @(posedge clk) begin
        if (fifo_read && q.size() != 0) begin
            pop_w = q.pop_front();
            fifo_data_out <= pop_w;
        end
    end

    always @(negedge clk) fifo_empty <= (q.size() == 0);

    always @(posedge clk) begin
        if (rst_ && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (rst_ && fifo_read && fifo_empty) rd_viol++;
        if (rst_ && out_valid_1 && out_last_1 !== 1'b1) last1_viol++;
        if (fifo_read_1 !== fifo_read || out_data_1 !== out_data) dut1_mis++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_got(input int target, input int limit);
        n = 0;
        while (got_d.size() < target && n < limit) begin
            tick();
            n++;
        end
        chk("wait_beats", got_d.size(), target);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_read", fifo_read, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_words", words_sent, 0);
        chk("rst_busy", busy, 0);
        rst_ = 1'b1;
        tick();

        // streaming 8 words
        b = got_d.size();
        for (int i = 1; i <= 8; i++) q.push_back(16'(i));
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("s2_first_read", fifo_read, 1);
        chk("s2_lat_valid0", out_valid, 0);
        tick();
        chk("s2_lat_valid1", out_valid, 1);
        chk("s2_lat_data", out_data, 16'h0001);
        wait_got(b + 8, 40);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s2_d%0d", i), got_d[b+i], 16'(i + 1));
            chk($sformatf("s2_l%0d", i), got_l[b+i], (i == 3 || i == 7));
        end
        tick();
        tick();
        chk("s2_words", words_sent, 16'd8);
        chk("s2_idle_valid", out_valid, 0);
        chk("s2_busy", busy, 1);

        // backpressure
        b = got_d.size();
        for (int i = 1; i <= 8; i++) q.push_back(16'(i));
        wait_got(b + 2, 20);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("s3_noread%0d", k), fifo_read, 0);
            chk($sformatf("s3_hold_v%0d", k), out_valid, 1);
            chk($sformatf("s3_hold_d%0d", k), out_data, 16'h0003);
        end
        chk("s3_fifo_left", q.size(), 4);
        out_ready = 1'b1;
        wait_got(b + 8, 40);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s3_d%0d", i), got_d[b+i], 16'(i + 1));
            chk($sformatf("s3_l%0d", i), got_l[b+i], (i == 3 || i == 7));
        end
        tick();
        chk("s3_words", words_sent, 16'd16);

        // FIFO empty mid-burst
        b = got_d.size();
        q.push_back(16'h000A);
        q.push_back(16'h000B);
        wait_got(b + 2, 20);
        for (int k = 0; k < 4; k++) tick();
        chk("s4_valid_drop", out_valid, 0);
        chk("s4_l0", got_l[b], 0);
        chk("s4_l1", got_l[b+1], 0);
        chk("s4_words", words_sent, 16'd18);
        q.push_back(16'h000C);
        q.push_back(16'h000D);
        wait_got(b + 4, 20);
        chk("s4_d2", got_d[b+2], 16'h000C);
        chk("s4_l2", got_l[b+2], 0);
        chk("s4_d3", got_d[b+3], 16'h000D);
        chk("s4_l3", got_l[b+3], 1);
        tick();
        chk("s4_words2", words_sent, 16'd20);

        // disable during an in-flight read
        tick();
        b = got_d.size();
        q.push_back(16'h0021);
        q.push_back(16'h0022);
        q.push_back(16'h0023);
        tick();
        en = 1'b0;
        #1;
        chk("s5_read_off", fifo_read, 0);
        chk("s5_one_read", q.size(), 2);
        tick();
        chk("s5_drain_busy", busy, 1);
        chk("s5_drain_valid", out_valid, 1);
        chk("s5_drain_data", out_data, 16'h0021);
        tick();
        tick();
        chk("s5_idle_busy", busy, 0);
        chk("s5_idle_valid", out_valid, 0);
        chk("s5_no_more", q.size(), 2);
        chk("s5_got", got_d[b], 16'h0021);
        chk("s5_words", words_sent, 16'd21);

        // reset with a full buffer
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("s1_full_valid", out_valid, 1);
        chk("s1_full_data", out_data, 16'h0022);
        chk("s1_full_noread", fifo_read, 0);
        #2;
        rst_ = 1'b0;
        #1;
        chk("s1_read0", fifo_read, 0);
        chk("s1_valid0", out_valid, 0);
        chk("s1_data0", out_data, 0);
        chk("s1_last0", out_last, 0);
        chk("s1_words0", words_sent, 0);
        chk("s1_busy0", busy, 0);
        tick();
        tick();
        q.push_back(16'h0031);
        out_ready = 1'b1;
        rst_ = 1'b1;
        tick();
        chk("s1_rel_valid", out_valid, 0);
        tick();
        chk("s1_new_valid", out_valid, 1);
        chk("s1_new_data", out_data, 16'h0031);
        chk("s1_new_last", out_last, 0);
        chk("s1_new_words", words_sent, 0);
        tick();
        chk("s1_words1", words_sent, 1);

        // words_sent wrap, BURST_LEN=1 marker
        b = got_d.size();
        for (int i = 0; i < 65535; i++) q.push_back(16'(i));
        wait_got(b + 65534, 70000);
        chk("s6_words_max", words_sent, 16'hFFFF);
        wait_got(b + 65535, 10);
        chk("s6_wrap", words_sent, 16'h0000);
        chk("s6_wrap_b1", words_sent_1, 16'h0000);
        chk("s6_last_d", got_d[b+65534], 16'hFFFE);
        chk("s6_last_l", got_l[b+65534], 1);
        chk("s6_mid_l", got_l[b+65533], 0);

        chk("rd_safety", rd_viol, 0);
        chk("b1_last", last1_viol, 0);
        chk("b1_match", dut1_mis, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
